// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/RAM arbiter: word type, RAM handshake states and the
// arbiter FSM encoding (exposed so benches and monitors can decode the state).
package cache_mem_arbiter_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

   localparam int TIMEOUT_CYC_DEFAULT = 64;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM-side handshake signals around the arbiter.
// slave = arbiter view, master = caches + RAM view.
interface cache_mem_arbiter_if;
   import cache_mem_arbiter_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;

   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;

   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/cache_mem_arbiter_timeout_ctr.sv
// Saturating grant-cycle counter with a sticky timeout flag; the flag never aborts
// the transfer, it only reports it. Cleared only by nRST.
module cache_mem_arbiter_timeout_ctr #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic CLK,
   input  logic nRST,
   input  logic clear_i,
   input  logic count_i,
   output logic timeout_o
);

   localparam int            CW       = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_TRIP = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;

   // Trip on the cycle that would be the TIMEOUT_CYC-th without ACCESS.
   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         if (cnt_q >= CNT_TRIP) flag_d = 1'b1;
         if (cnt_q != CNT_MAX)  cnt_d  = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign timeout_o = flag_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single-ported RAM between icache and dcache; holds a grant until ACCESS.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is dcache-over-icache.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic                CLK,
   input  logic                nRST,
   cache_mem_arbiter_if.slave  bus,
   output logic                mem_timeout,
   output logic                mem_error
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_IGRANT = IGRANT;
   localparam logic [1:0] ST_DGRANT = DGRANT;

   logic [1:0] state_q, state_d;
   logic       mem_error_q, mem_error_d;
   logic       i_req, d_req, i_gnt, d_gnt;
   logic       ram_access, ram_error, d_wins;

   assign i_req      = bus.iREN;
   assign d_req      = bus.dREN | bus.dWEN;
   assign i_gnt      = (state_q == ST_IGRANT) & i_req;
   assign d_gnt      = (state_q == ST_DGRANT) & d_req;
   assign ram_access = (bus.ramstate == ACCESS);
   assign ram_error  = (bus.ramstate == ERROR);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;

   // last_d_q = 1 when the dcache finished the most recent transfer.
   always_comb begin
      last_d_d = last_d_q;
      if (i_gnt & ram_access) last_d_d = 1'b0;
      if (d_gnt & ram_access) last_d_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) last_d_q <= 1'b0;
      else       last_d_q <= last_d_d;
   end

   assign d_wins = d_req & (~i_req | ~last_d_q);
`else
   assign d_wins = d_req;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (d_wins)     state_d = ST_DGRANT;
            else if (i_req) state_d = ST_IGRANT;
         end
         ST_IGRANT: if (!i_req || ram_access || ram_error) state_d = ST_IDLE;
         ST_DGRANT: if (!d_req || ram_access || ram_error) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign mem_error_d = mem_error_q | ((i_gnt | d_gnt) & ram_error);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_error_q <= mem_error_d;
      end
   end

   // RAM side follows the live request, so a dropped request releases the RAM at once.
   assign bus.ramREN   = i_gnt | (d_gnt & ~bus.dWEN);
   assign bus.ramWEN   = d_gnt & bus.dWEN;
   assign bus.ramaddr  = d_gnt ? bus.daddr : (i_gnt ? bus.iaddr : '0);
   assign bus.ramstore = d_gnt ? bus.dstore : '0;

   assign bus.iwait = ~(i_gnt & ram_access);
   assign bus.dwait = ~(d_gnt & ram_access);
   assign bus.iload = (i_gnt & ram_access) ? bus.ramload : '0;
   assign bus.dload = (d_gnt & ram_access) ? bus.ramload : '0;

   cache_mem_arbiter_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .CLK       (CLK),
      .nRST      (nRST),
      .clear_i   (state_q == ST_IDLE),
      .count_i   ((i_gnt | d_gnt) & ~ram_access),
      .timeout_o (mem_timeout)
   );

   assign mem_error = mem_error_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed + randomized bench for cache_mem_arbiter with a behavioural RAM and memory model.
module tb_cache_mem_arbiter;
   import cache_mem_arbiter_pkg::*;

   localparam int TO = 64;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic mem_timeout, mem_error;

   cache_mem_arbiter_if bus();

   cache_mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .bus         (bus),
      .mem_timeout (mem_timeout),
      .mem_error   (mem_error)
   );

   always #5 CLK = ~CLK;

   int    n_tests = 0;
   int    n_fail  = 0;
   word_t ram_mem [16];
   word_t ref_mem [16];
   int    ram_cnt = 0;
   int    ram_lat = 0;
   bit    ram_err_next = 0, ram_hold_busy = 0, ram_rand = 0;
   bit    exp_err = 0, exp_to = 0;
   bit    i_done, d_done;
   logic  s_ramREN, s_ramWEN, s_iwait, s_dwait, s_timeout;
   word_t s_ramaddr, s_ramstore, s_dload;

   function automatic int widx(input word_t a);
      return int'((a >> 2) & 32'hF);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic new_txn();
      if (ram_rand) begin
         ram_lat      = $urandom_range(0, 3);
         ram_err_next = ($urandom_range(0, 9) == 0);
      end
   endtask

   // One clock cycle: RAM responds, outputs are checked, then the edge is taken.
   task automatic run_cycle();
      logic  en, wr;
      word_t a, st;
      #1;
      en = bus.ramREN | bus.ramWEN;
      wr = bus.ramWEN;
      a  = bus.ramaddr;
      st = bus.ramstore;
      if (en) begin
         if (ram_hold_busy || ram_cnt < ram_lat) bus.ramstate = BUSY;
         else if (ram_err_next)                  bus.ramstate = ERROR;
         else                                    bus.ramstate = ACCESS;
         bus.ramload = (bus.ramstate == ACCESS && !wr) ? ram_mem[widx(a)] : word_t'($urandom);
      end else begin
         bus.ramstate = FREE;
         bus.ramload  = word_t'($urandom);
      end
      #1;
      i_done = (bus.iwait === 1'b0);
      d_done = (bus.dwait === 1'b0);
      s_ramREN = bus.ramREN;  s_ramWEN = bus.ramWEN;
      s_ramaddr = bus.ramaddr; s_ramstore = bus.ramstore;
      s_iwait = bus.iwait; s_dwait = bus.dwait; s_dload = bus.dload;
      s_timeout = mem_timeout;
      chk("wait_excl", 32'(i_done && d_done), 0);
      if (!i_done) chk("iload_idle", bus.iload, 0);
      if (!d_done) chk("dload_idle", bus.dload, 0);
      if (i_done) begin
         chk("i_done_cond", 32'(bus.iREN && bus.ramstate == ACCESS && bus.ramREN), 1);
         chk("iload", bus.iload, ref_mem[widx(bus.iaddr)]);
      end
      if (d_done) begin
         chk("d_done_cond", 32'((bus.dREN || bus.dWEN) && bus.ramstate == ACCESS && en), 1);
         if (bus.dWEN) ref_mem[widx(bus.daddr)] = bus.dstore;
         else          chk("dload", bus.dload, ref_mem[widx(bus.daddr)]);
      end
      if (wr)
         chk("ram_wr_route", 32'(bus.dWEN && !bus.ramREN && bus.ramaddr === bus.daddr
                                 && bus.ramstore === bus.dstore), 1);
      else if (bus.ramREN)
         chk("ram_rd_route", 32'((bus.dREN && !bus.dWEN && bus.ramaddr === bus.daddr)
                                 || (bus.iREN && bus.ramaddr === bus.iaddr)), 1);
      chk("mem_error", 32'(mem_error), 32'(exp_err));
      chk("mem_timeout", 32'(mem_timeout), 32'(exp_to));
      @(posedge CLK);
      if (en) begin
         case (bus.ramstate)
            ACCESS: begin
               if (wr) ram_mem[widx(a)] = st;
               ram_cnt = 0;
               new_txn();
            end
            ERROR: begin
               ram_err_next = 0;
               exp_err      = 1;
               ram_cnt      = 0;
               new_txn();
            end
            default: ram_cnt++;
         endcase
      end else begin
         ram_cnt = 0;
      end
      #1;
   endtask

   task automatic wait_done(input bit want_d, input int bound, output int n);
      n = 0;
      do begin
         run_cycle();
         n++;
      end while (!(want_d ? d_done : i_done) && n < bound);
      chk(want_d ? "d_done_bound" : "i_done_bound", 32'(want_d ? d_done : i_done), 1);
   endtask

   task automatic both_req(input bit exp_d_first, input word_t ia, input word_t da);
      int n;
      ram_lat = 1;
      bus.iREN = 1; bus.iaddr = ia;
      bus.dREN = 1; bus.daddr = da;
      run_cycle();
      chk("both_idle_noen", 32'(s_ramREN), 0);
      run_cycle();
      chk("both_first_addr", s_ramaddr, exp_d_first ? da : ia);
      wait_done(exp_d_first, 10, n);
      if (exp_d_first) bus.dREN = 0; else bus.iREN = 0;
      wait_done(!exp_d_first, 10, n);
      chk("both_second_lat", n, 3);
      bus.iREN = 0; bus.dREN = 0;
      run_cycle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int i_gap, d_gap, i_age, d_age;
      bit i_pend, d_pend;
      int op;

      bus.iREN = 0; bus.iaddr = '0;
      bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0; bus.dstore = '0;
      bus.ramload = '0; bus.ramstate = FREE;
      for (int k = 0; k < 16; k++) begin
         ram_mem[k] = word_t'($urandom);
         ref_mem[k] = ram_mem[k];
      end

      // Reset state
      #3;
      chk("rst_iwait", 32'(bus.iwait), 1);
      chk("rst_dwait", 32'(bus.dwait), 1);
      chk("rst_ramREN", 32'(bus.ramREN), 0);
      chk("rst_ramWEN", 32'(bus.ramWEN), 0);
      chk("rst_flags", {30'd0, mem_error, mem_timeout}, 0);
      @(posedge CLK); @(posedge CLK); #1;
      nRST = 1;

      // Simultaneous requests straight after reset: dcache first in both modes
      both_req(1'b1, 32'h44, 32'h8C);

      // icache read, 3 BUSY then ACCESS
      ram_lat = 3;
      bus.iREN = 1; bus.iaddr = 32'h40;
      run_cycle();
      chk("i_grant_latency", 32'(s_ramREN), 0);
      wait_done(1'b0, 20, n);
      chk("i_access_cycles", n, 4);
      chk("i_ramREN", 32'(s_ramREN), 1);
      chk("i_ramaddr", s_ramaddr, 32'h40);
      bus.iREN = 0;
      run_cycle();
      chk("i_done_single", 32'(s_iwait), 1);

      // dcache write then readback
      ram_lat = 2;
      bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF;
      wait_done(1'b1, 20, n);
      chk("d_wr_cycles", n, 4);
      chk("d_ramWEN", 32'(s_ramWEN), 1);
      chk("d_ramstore", s_ramstore, 32'hDEADBEEF);
      chk("d_ramaddr", s_ramaddr, 32'h80);
      bus.dWEN = 0;
      run_cycle();
      chk("d_done_single", 32'(s_dwait), 1);
      bus.dREN = 1;
      wait_done(1'b1, 20, n);
      chk("d_readback", s_dload, 32'hDEADBEEF);
      bus.dREN = 0;
      run_cycle();

      // dcache finished last: round robin hands priority to icache
      both_req(!RR, 32'h50, 32'h90);

      // ERROR once during DGRANT: flagged, retried, then done
      ram_lat = 1; ram_err_next = 1;
      bus.dREN = 1; bus.daddr = 32'h84;
      wait_done(1'b1, 20, n);
      chk("err_retry_cycles", n, 6);
      chk("err_flag", 32'(mem_error), 1);
      bus.dREN = 0;
      run_cycle();

      // Grant held BUSY past the timeout
      ram_hold_busy = 1;
      bus.iREN = 1; bus.iaddr = 32'h48;
      run_cycle();
      for (int k = 1; k <= TO + 1; k++) begin
         run_cycle();
         if (k == TO) begin
            chk("to_before_limit", 32'(s_timeout), 0);
            exp_to = 1;
         end
      end
      chk("to_set", 32'(s_timeout), 1);
      chk("to_grant_held", 32'(s_ramREN), 1);
      chk("to_iwait_held", 32'(s_iwait), 1);
      ram_hold_busy = 0; ram_lat = 0;
      wait_done(1'b0, 5, n);
      bus.iREN = 0;
      run_cycle();

      // Request dropped mid-grant
      ram_lat = 3;
      bus.dREN = 1; bus.daddr = 32'h88;
      run_cycle();
      run_cycle();
      chk("drop_granted", 32'(s_ramREN), 1);
      bus.dREN = 0;
      run_cycle();
      chk("drop_ramREN", 32'(s_ramREN), 0);
      chk("drop_dwait", 32'(s_dwait), 1);
      bus.iREN = 1; bus.iaddr = 32'h4C;
      wait_done(1'b0, 20, n);
      chk("after_drop_cycles", n, 5);
      bus.iREN = 0;
      run_cycle();

      // Asynchronous reset mid-IGRANT
      ram_lat = 3;
      bus.iREN = 1; bus.iaddr = 32'h54;
      run_cycle();
      run_cycle();
      nRST = 0;
      #1;
      chk("arst_ramREN", 32'(bus.ramREN), 0);
      chk("arst_iwait", 32'(bus.iwait), 1);
      chk("arst_dwait", 32'(bus.dwait), 1);
      chk("arst_flags", {30'd0, mem_error, mem_timeout}, 0);
      exp_err = 0; exp_to = 0;
      run_cycle();
      run_cycle();
      nRST = 1;
      wait_done(1'b0, 20, n);
      chk("arst_regrant_cycles", n, 5);
      bus.iREN = 0;
      run_cycle();

      // Randomized traffic against the memory model
      ram_rand = 1;
      new_txn();
      i_gap = 0; d_gap = 0; i_age = 0; d_age = 0; i_pend = 0; d_pend = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!i_pend) begin
            if (i_gap > 0) i_gap--;
            else if ($urandom_range(0, 2) == 0) begin
               i_pend = 1; i_age = 0;
               bus.iREN = 1;
               bus.iaddr = 32'h40 + 32'(4 * $urandom_range(0, 15));
            end
         end else if (i_age > 3 && $urandom_range(0, 99) == 0) begin
            i_pend = 0; bus.iREN = 0; i_gap = 2;
         end
         if (!d_pend) begin
            if (d_gap > 0) d_gap--;
            else if ($urandom_range(0, 2) == 0) begin
               d_pend = 1; d_age = 0;
               op = $urandom_range(0, 3);
               bus.dREN   = (op != 2);
               bus.dWEN   = (op >= 2);
               bus.daddr  = 32'h40 + 32'(4 * $urandom_range(0, 15));
               bus.dstore = word_t'($urandom);
            end
         end else if (d_age > 3 && $urandom_range(0, 99) == 0) begin
            d_pend = 0; bus.dREN = 0; bus.dWEN = 0; d_gap = 2;
         end
         run_cycle();
         if (i_pend) begin
            i_age++;
            if (i_done) begin
               i_pend = 0; bus.iREN = 0; i_gap = $urandom_range(1, 4);
            end else if (i_age > 200) begin
               chk("i_starved", 0, 1);
               i_pend = 0; bus.iREN = 0;
            end
         end
         if (d_pend) begin
            d_age++;
            if (d_done) begin
               d_pend = 0; bus.dREN = 0; bus.dWEN = 0; d_gap = $urandom_range(1, 4);
            end else if (d_age > 200) begin
               chk("d_starved", 0, 1);
               d_pend = 0; bus.dREN = 0; bus.dWEN = 0;
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
